core_sequencer: RTL and testbench

Multi-cycle sequencer for the RV64 integer/FP core. It steps each instruction through fetch, decode, execute/FPU-wait, memory and write-back, and drives the handshakes to instruction memory, data memory and the multi-cycle FPU divide/multiply unit. It produces the register-file and PC write strobes that gate the combinational decoder's datapath controls, and counts retired instructions.

---
 rtl/core_pkg.sv | 55 +++++
 rtl/core_seq_classify.sv | 45 ++++
 rtl/core_sequencer.sv | 154 +++++++++++++++
 tb/tb_core_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the RV64 core sequencer and decoder.
//   - RV64 major opcode constants
//   - sequencer state enum
//   - instruction class enum produced by core_seq_classify
//   - helper to recognise FP-to-integer-result funct7 encodings
package core_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP     = 7'b1010011;

  // OP_FP funct5 values that need the multi-cycle FPU
  localparam logic [4:0] F5_FMUL = 5'b00010;
  localparam logic [4:0] F5_FDIV = 5'b00011;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_FPU_WAIT,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CL_INT,
    CL_BR,
    CL_LD,
    CL_ST,
    CL_FLD,
    CL_FST,
    CL_FP,
    CL_FP2INT,
    CL_FPU_MC
  } class_e;

  // FP compare / classify / move / convert-to-int: result lands in the integer RF
  function automatic logic is_fp2int(input logic [6:0] f7);
    return (f7 == 7'b1100000) || (f7 == 7'b1100001) ||
           (f7 == 7'b1010000) || (f7 == 7'b1010001) ||
           (f7 == 7'b1110000) || (f7 == 7'b1110001);
  endfunction

endpackage

// File: rtl/core_seq_classify.sv
// core_seq_classify: combinational instruction classifier.
//   i_inst    : instruction register contents
//   o_cls     : instruction class (meaningful only when o_illegal = 0)
//   o_illegal : opcode not recognised
module core_seq_classify
  import core_pkg::*;
(
  input  logic [31:0] i_inst,
  output class_e      o_cls,
  output logic        o_illegal
);

  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic       w_unused_bits;

  assign w_opc         = i_inst[6:0];
  assign w_f7          = i_inst[31:25];
  assign w_unused_bits = ^i_inst[24:7];

  always_comb begin
    o_cls     = CL_INT;
    o_illegal = 1'b0;
    case (w_opc)
      OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: o_cls = CL_INT;
      OPC_BRANCH:   o_cls = CL_BR;
      OPC_LOAD:     o_cls = CL_LD;
      OPC_STORE:    o_cls = CL_ST;
      OPC_LOAD_FP:  o_cls = CL_FLD;
      OPC_STORE_FP: o_cls = CL_FST;
      OPC_OP_FP: begin
        if ((w_f7[6:2] == F5_FMUL) || (w_f7[6:2] == F5_FDIV)) begin
          o_cls = CL_FPU_MC;
        end else if (is_fp2int(w_f7)) begin
          o_cls = CL_FP2INT;
        end else begin
          o_cls = CL_FP;
        end
      end
      default:      o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle instruction sequencer for the RV64 core.
// Steps each instruction through FETCH, DECODE, FPU_WAIT/MEM, WB (or TRAP)
// and drives the memory / FPU handshakes and register-file / PC strobes.
//   in_clk, in_rst_n   : clock, async active-low reset
//   in_inst            : instruction register contents
//   in_imem_ack        : instruction fetch complete
//   in_dmem_ack        : data access complete
//   in_fpu_done        : multi-cycle FPU result valid
//   out_imem_req       : fetch request (level until ack)
//   out_ir_we          : load instruction register (FETCH & ack)
//   out_dmem_req/_we   : data request / write qualifier
//   out_fpu_start      : FPU start pulse
//   out_rf_we/frf_we   : integer / FP register file write
//   out_pc_we          : PC update
//   out_illegal        : unrecognised opcode pulse
//   out_fpu_timeout    : FPU wait expired pulse
//   out_retire_cnt     : retired-instruction count
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned FPU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic [31:0]      in_inst,
  input  logic             in_imem_ack,
  input  logic             in_dmem_ack,
  input  logic             in_fpu_done,
  output logic             out_imem_req,
  output logic             out_ir_we,
  output logic             out_dmem_req,
  output logic             out_dmem_we,
  output logic             out_fpu_start,
  output logic             out_rf_we,
  output logic             out_frf_we,
  output logic             out_pc_we,
  output logic             out_illegal,
  output logic             out_fpu_timeout,
  output logic [CNT_W-1:0] out_retire_cnt
);

  localparam int unsigned   TO_W    = (FPU_TIMEOUT > 1) ? $clog2(FPU_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FPU_TIMEOUT - 1);

  state_e           r_state;
  state_e           w_next;
  class_e           r_cls;
  class_e           w_cls;
  logic             w_illegal;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_trap_ill;
  logic [CNT_W-1:0] r_retire;

  core_seq_classify u_classify (
    .i_inst    (in_inst),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state    <= ST_FETCH;
      r_cls      <= CL_INT;
      r_to_cnt   <= '0;
      r_trap_ill <= 1'b0;
      r_retire   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_cls <= w_cls;
      end
      // held at zero outside the wait so it is already cleared on entry
      if (r_state == ST_FPU_WAIT) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
      // remembers why TRAP was entered so both pulses stay Moore outputs
      if (w_next == ST_TRAP) begin
        r_trap_ill <= (r_state == ST_DECODE);
      end
      if (r_state == ST_WB) begin
        r_retire <= r_retire + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    out_imem_req    = 1'b0;
    out_ir_we       = 1'b0;
    out_dmem_req    = 1'b0;
    out_dmem_we     = 1'b0;
    out_fpu_start   = 1'b0;
    out_rf_we       = 1'b0;
    out_frf_we      = 1'b0;
    out_pc_we       = 1'b0;
    out_illegal     = 1'b0;
    out_fpu_timeout = 1'b0;
    case (r_state)
      ST_FETCH: begin
        out_imem_req = 1'b1;
        out_ir_we    = in_imem_ack;
        if (in_imem_ack) begin
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_illegal) begin
          w_next = ST_TRAP;
        end else begin
          case (w_cls)
            CL_LD, CL_ST, CL_FLD, CL_FST: w_next = ST_MEM;
            CL_FPU_MC:                    w_next = ST_FPU_WAIT;
            default:                      w_next = ST_WB;
          endcase
        end
      end
      ST_FPU_WAIT: begin
        out_fpu_start = (r_to_cnt == '0);
        // done is tested first so it wins over a coincident timeout
        if (in_fpu_done) begin
          w_next = ST_WB;
        end else if (r_to_cnt == TO_LAST) begin
          w_next = ST_TRAP;
        end
      end
      ST_MEM: begin
        out_dmem_req = 1'b1;
        out_dmem_we  = (r_cls == CL_ST) || (r_cls == CL_FST);
        if (in_dmem_ack) begin
          w_next = ST_WB;
        end
      end
      ST_WB: begin
        out_pc_we  = 1'b1;
        out_rf_we  = (r_cls == CL_INT) || (r_cls == CL_LD) || (r_cls == CL_FP2INT);
        out_frf_we = (r_cls == CL_FLD) || (r_cls == CL_FP) || (r_cls == CL_FPU_MC);
        w_next     = ST_FETCH;
      end
      ST_TRAP: begin
        out_pc_we       = 1'b1;
        out_illegal     = r_trap_ill;
        out_fpu_timeout = !r_trap_ill;
        w_next          = ST_FETCH;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  assign out_retire_cnt = r_retire;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with a write-back scoreboard.
module tb_core_sequencer;

  logic        in_clk;
  logic        in_rst_n;
  logic [31:0] in_inst;
  logic        in_imem_ack;
  logic        in_dmem_ack;
  logic        in_fpu_done;
  logic        out_imem_req;
  logic        out_ir_we;
  logic        out_dmem_req;
  logic        out_dmem_we;
  logic        out_fpu_start;
  logic        out_rf_we;
  logic        out_frf_we;
  logic        out_pc_we;
  logic        out_illegal;
  logic        out_fpu_timeout;
  logic [31:0] out_retire_cnt;

  core_sequencer #(.FPU_TIMEOUT(64), .CNT_W(32)) dut (
    .in_clk          (in_clk),
    .in_rst_n        (in_rst_n),
    .in_inst         (in_inst),
    .in_imem_ack     (in_imem_ack),
    .in_dmem_ack     (in_dmem_ack),
    .in_fpu_done     (in_fpu_done),
    .out_imem_req    (out_imem_req),
    .out_ir_we       (out_ir_we),
    .out_dmem_req    (out_dmem_req),
    .out_dmem_we     (out_dmem_we),
    .out_fpu_start   (out_fpu_start),
    .out_rf_we       (out_rf_we),
    .out_frf_we      (out_frf_we),
    .out_pc_we       (out_pc_we),
    .out_illegal     (out_illegal),
    .out_fpu_timeout (out_fpu_timeout),
    .out_retire_cnt  (out_retire_cnt)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  localparam logic [31:0] I_ADDI  = 32'h00100093;
  localparam logic [31:0] I_BEQ   = 32'h00000063;
  localparam logic [31:0] I_SW    = 32'h00112023;
  localparam logic [31:0] I_LW    = 32'h00012083;
  localparam logic [31:0] I_FLD   = 32'h00013087;
  localparam logic [31:0] I_FSD   = 32'h00113027;
  localparam logic [31:0] I_FDIVD = {7'b0001101, 5'd2, 5'd1, 3'b111, 5'd3, 7'b1010011};
  localparam logic [31:0] I_FMULS = {7'b0001000, 5'd2, 5'd1, 3'b111, 5'd3, 7'b1010011};
  localparam logic [31:0] I_FEQS  = {7'b1010000, 5'd2, 5'd1, 3'b010, 5'd3, 7'b1010011};
  localparam logic [31:0] I_FADDS = {7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3, 7'b1010011};
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  typedef struct {
    logic        rf;
    logic        frf;
    logic        ill;
    logic        to;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wb(input logic rf, input logic frf);
    exp_cnt = exp_cnt + 32'd1;
    sb.push_back('{rf: rf, frf: frf, ill: 1'b0, to: 1'b0, cnt: exp_cnt});
  endtask

  task automatic expect_trap(input logic ill, input logic to);
    sb.push_back('{rf: 1'b0, frf: 1'b0, ill: ill, to: to, cnt: exp_cnt});
  endtask

  // FETCH (with optional ack delay) then DECODE; returns at DECODE negedge
  task automatic do_fetch(input logic [31:0] inst, input int unsigned wait_cyc);
    for (int unsigned i = 0; i < wait_cyc; i++) begin
      @(negedge in_clk);
      in_inst = inst;
      in_imem_ack = 1'b0;
      #1;
      chk("fetch_req_hold", out_imem_req, 1);
      chk("fetch_no_ir_we", out_ir_we, 0);
    end
    @(negedge in_clk);
    in_inst = inst;
    in_imem_ack = 1'b1;
    #1;
    chk("fetch_req", out_imem_req, 1);
    chk("fetch_ir_we", out_ir_we, 1);
    @(negedge in_clk);
    in_imem_ack = 1'b0;
    #1;
    chk("decode_quiet",
        {out_imem_req, out_ir_we, out_pc_we, out_rf_we, out_frf_we, out_dmem_req, out_fpu_start},
        7'b0);
  endtask

  task automatic mem_phase(input int unsigned ack_delay, input logic we_exp);
    for (int unsigned i = 0; i <= ack_delay; i++) begin
      @(negedge in_clk);
      in_dmem_ack = (i == ack_delay);
      #1;
      chk("mem_req", out_dmem_req, 1);
      chk("mem_we", out_dmem_we, we_exp);
    end
    @(negedge in_clk);
    in_dmem_ack = 1'b0;
    #1;
    chk("mem_released", out_dmem_req, 0);
  endtask

  // FPU wait; done_at >= 64 means never done. Returns at WB/TRAP negedge.
  task automatic fpu_phase(input int unsigned done_at);
    int unsigned n_start;
    n_start = 0;
    for (int unsigned k = 0; k < 64; k++) begin
      @(negedge in_clk);
      in_fpu_done = (k == done_at);
      #1;
      chk("fpu_start_level", out_fpu_start, (k == 0));
      chk("fpu_no_early_timeout", out_fpu_timeout, 0);
      if (out_fpu_start) n_start++;
      if (k == done_at) break;
    end
    chk("fpu_start_pulses", n_start, 1);
    @(negedge in_clk);
    in_fpu_done = 1'b0;
    #1;
  endtask

  // Scoreboard consumer: every PC update must match the oldest expectation
  always @(negedge in_clk) begin
    #2;
    if (in_rst_n && out_pc_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_pc_we", out_pc_we, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_rf_we", out_rf_we, mon_e.rf);
        chk("sb_frf_we", out_frf_we, mon_e.frf);
        chk("sb_illegal", out_illegal, mon_e.ill);
        chk("sb_fpu_timeout", out_fpu_timeout, mon_e.to);
        @(negedge in_clk);
        #2;
        chk("sb_retire_cnt", out_retire_cnt, mon_e.cnt);
        chk("sb_back_to_fetch", out_imem_req, 1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_rst_n    = 1'b0;
    in_inst     = '0;
    in_imem_ack = 1'b0;
    in_dmem_ack = 1'b0;
    in_fpu_done = 1'b0;
    repeat (2) @(negedge in_clk);
    #1;
    chk("rst_imem_req", out_imem_req, 1);
    chk("rst_strobes",
        {out_ir_we, out_dmem_req, out_dmem_we, out_fpu_start, out_rf_we, out_frf_we,
         out_pc_we, out_illegal, out_fpu_timeout}, 9'b0);
    chk("rst_retire_cnt", out_retire_cnt, 0);
    @(negedge in_clk);
    in_rst_n = 1'b1;

    // ADDI: ir_we at cycle 0, WB at cycle 2
    expect_wb(1'b1, 1'b0);
    do_fetch(I_ADDI, 0);
    @(negedge in_clk);
    #1;
    chk("addi_wb_pc_we", out_pc_we, 1);
    chk("addi_wb_rf_we", out_rf_we, 1);

    // BEQ with spurious dmem ack / fpu done that must be ignored
    in_dmem_ack = 1'b1;
    in_fpu_done = 1'b1;
    expect_wb(1'b0, 1'b0);
    do_fetch(I_BEQ, 2);
    @(negedge in_clk);
    in_dmem_ack = 1'b0;
    in_fpu_done = 1'b0;
    #1;
    chk("beq_wb_pc_we", out_pc_we, 1);

    // SW with dmem ack delayed 3 cycles
    expect_wb(1'b0, 1'b0);
    do_fetch(I_SW, 1);
    mem_phase(3, 1'b1);

    // LW, FLD, FSD
    expect_wb(1'b1, 1'b0);
    do_fetch(I_LW, 0);
    mem_phase(0, 1'b0);
    expect_wb(1'b0, 1'b1);
    do_fetch(I_FLD, 0);
    mem_phase(1, 1'b0);
    expect_wb(1'b0, 1'b0);
    do_fetch(I_FSD, 0);
    mem_phase(0, 1'b1);

    // FDIV.D done after 10 cycles
    expect_wb(1'b0, 1'b1);
    do_fetch(I_FDIVD, 0);
    fpu_phase(10);
    chk("fdiv_wb_frf_we", out_frf_we, 1);

    // Zero-latency FPU
    expect_wb(1'b0, 1'b1);
    do_fetch(I_FMULS, 0);
    fpu_phase(0);
    chk("fmul0_wb_pc_we", out_pc_we, 1);

    // FEQ.S writes the integer RF; FADD.S writes the FP RF
    expect_wb(1'b1, 1'b0);
    do_fetch(I_FEQS, 0);
    @(negedge in_clk);
    expect_wb(1'b0, 1'b1);
    do_fetch(I_FADDS, 0);
    @(negedge in_clk);

    // FMUL.S never done: timeout then TRAP, count unchanged
    expect_trap(1'b0, 1'b1);
    do_fetch(I_FMULS, 0);
    fpu_phase(1000);
    chk("timeout_pulse", out_fpu_timeout, 1);
    chk("timeout_pc_we", out_pc_we, 1);

    // Done coincident with last timeout cycle: done wins
    expect_wb(1'b0, 1'b1);
    do_fetch(I_FMULS, 0);
    fpu_phase(63);
    chk("done_wins_no_timeout", out_fpu_timeout, 0);
    chk("done_wins_frf_we", out_frf_we, 1);

    // Illegal opcode
    expect_trap(1'b1, 1'b0);
    do_fetch(I_BAD, 0);
    @(negedge in_clk);
    #1;
    chk("illegal_pulse", out_illegal, 1);
    @(negedge in_clk);
    #1;
    chk("illegal_one_cycle", out_illegal, 0);
    chk("illegal_back_fetch", out_imem_req, 1);

    // Reset asserted during MEM
    do_fetch(I_LW, 0);
    @(negedge in_clk);
    #1;
    chk("pre_rst_dmem_req", out_dmem_req, 1);
    in_rst_n = 1'b0;
    #1;
    chk("rst_async_dmem_req", out_dmem_req, 0);
    chk("rst_async_imem_req", out_imem_req, 1);
    chk("rst_async_cnt", out_retire_cnt, 0);
    chk("rst_async_writes", {out_pc_we, out_rf_we, out_frf_we}, 3'b0);
    exp_cnt = '0;
    @(negedge in_clk);
    #1;
    chk("rst_hold_dmem_req", out_dmem_req, 0);
    in_rst_n = 1'b1;

    // Recovery after reset
    expect_wb(1'b1, 1'b0);
    do_fetch(I_ADDI, 0);
    @(negedge in_clk);
    repeat (3) @(negedge in_clk);
    #3;
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
